regfile_wr_arbiter: RTL and testbench

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

---
 rtl/regfile_wr_arbiter_pkg.sv | 15 +
 rtl/regfile_wr_arbiter_rr_grant.sv | 31 +++
 rtl/regfile_wr_arbiter.sv | 128 ++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter.
//   state_e  : controller state encoding (clear sweep, then arbitration)
//   NumRegs  : number of architectural registers cleared by the sweep
//   RegIdxW  : width of a register index
package regfile_wr_arbiter_pkg;

    localparam int unsigned NumRegs = 32;
    localparam int unsigned RegIdxW = 5;

    typedef enum logic {
        StInit = 1'b0,
        StArb  = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_wr_arbiter_rr_grant.sv
// Combinational round-robin grant: picks the first valid requester at or
// after ptr, scanning upward and wrapping at NREQ.
//   valid : per-requester request vector
//   ptr   : highest-priority requester index for this cycle
//   grant : one-hot grant, all zeros when nothing is valid
module rr_grant #(
    parameter int unsigned NREQ = 3,
    localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PtrW-1:0] ptr,
    output logic [NREQ-1:0] grant
);

    always_comb begin
        int unsigned idx;
        logic [NREQ-1:0] rot;
        grant = '0;
        idx   = 0;
        rot   = '0;
        // Scan from the farthest offset down so the nearest valid one wins.
        for (int off = NREQ - 1; off >= 0; off--) begin
            idx = (int'(ptr) + off) % NREQ;
            rot = valid >> idx;
            if (rot[0]) begin
                grant = NREQ'(1) << idx;
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write arbiter. After reset it clears x0..x31 with one write
// per cycle, then arbitrates NREQ write requesters round-robin, issuing the
// winner's write one cycle after its handshake. Writes to x0 are dropped.
//   clk, reset_n  : clock, asynchronous active-low reset
//   req_valid_pi  : per-requester write request
//   req_ready_po  : per-requester grant (combinational, at most one hot)
//   req_dest_pi   : per-requester destination index, 5-bit slices
//   req_data_pi   : per-requester write data, DW-bit slices
//   we_po         : register-file write enable
//   destReg_po    : register-file write index
//   writeData_po  : register-file write data
//   init_done_po  : high once the clear sweep has finished
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned DW   = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req_valid_pi,
    output logic [NREQ-1:0]         req_ready_po,
    input  logic [NREQ*RegIdxW-1:0] req_dest_pi,
    input  logic [NREQ*DW-1:0]      req_data_pi,
    output logic                    we_po,
    output logic [RegIdxW-1:0]      destReg_po,
    output logic [DW-1:0]           writeData_po,
    output logic                    init_done_po
);

    localparam int unsigned PtrW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    // One extra bit so the counter can sit at NumRegs for the hand-over cycle.
    localparam int unsigned SweepW = RegIdxW + 1;

    state_e              state_q, state_d;
    logic [SweepW-1:0]   sweep_q, sweep_d;
    logic [PtrW-1:0]     ptr_q, ptr_d;
    logic                we_q, we_d;
    logic [RegIdxW-1:0]  dest_q, dest_d;
    logic [DW-1:0]       data_q, data_d;

    logic [NREQ-1:0]     grant_raw;
    logic [NREQ-1:0]     grant;
    logic                hs;
    logic [PtrW-1:0]     gidx;
    logic [RegIdxW-1:0]  sel_dest;
    logic [DW-1:0]       sel_data;

    rr_grant #(
        .NREQ (NREQ)
    ) u_rr_grant (
        .valid (req_valid_pi),
        .ptr   (ptr_q),
        .grant (grant_raw)
    );

    assign grant        = (state_q == StArb) ? grant_raw : '0;
    assign hs           = |grant;
    assign req_ready_po = grant;

    // Mux the granted requester's payload and index.
    always_comb begin
        gidx     = '0;
        sel_dest = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gidx     = PtrW'(i);
                sel_dest = req_dest_pi[i*RegIdxW +: RegIdxW];
                sel_data = req_data_pi[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        dest_d  = dest_q;
        data_d  = data_q;
        case (state_q)
            StInit: begin
                if (sweep_q == SweepW'(NumRegs)) begin
                    state_d = StArb;
                end else begin
                    we_d    = 1'b1;
                    dest_d  = sweep_q[RegIdxW-1:0];
                    data_d  = '0;
                    sweep_d = sweep_q + SweepW'(1);
                end
            end
            StArb: begin
                if (hs) begin
                    we_d   = (sel_dest != '0);
                    dest_d = sel_dest;
                    data_d = sel_data;
                    ptr_d  = (gidx == PtrW'(NREQ - 1)) ? '0 : gidx + PtrW'(1);
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StInit;
            sweep_q <= '0;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            dest_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            dest_q  <= dest_d;
            data_q  <= data_d;
        end
    end

    assign we_po        = we_q;
    assign destReg_po   = dest_q;
    assign writeData_po = data_q;
    assign init_done_po = (state_q == StArb);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

    localparam int unsigned NREQ = 3;
    localparam int unsigned DW   = 32;

    logic              clk;
    logic              reset_n;
    logic [NREQ-1:0]   req_valid_pi;
    logic [NREQ-1:0]   req_ready_po;
    logic [NREQ*5-1:0] req_dest_pi;
    logic [NREQ*DW-1:0] req_data_pi;
    logic              we_po;
    logic [4:0]        destReg_po;
    logic [DW-1:0]     writeData_po;
    logic              init_done_po;

    int n_cmp  = 0;
    int n_fail = 0;

    regfile_wr_arbiter #(
        .NREQ (NREQ),
        .DW   (DW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid_pi (req_valid_pi),
        .req_ready_po (req_ready_po),
        .req_dest_pi  (req_dest_pi),
        .req_data_pi  (req_data_pi),
        .we_po        (we_po),
        .destReg_po   (destReg_po),
        .writeData_po (writeData_po),
        .init_done_po (init_done_po)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  valid;
        logic [4:0]  d0, d1, d2;
        logic [31:0] x0, x1, x2;
        logic [2:0]  exp_ready;
        logic        exp_we;
        logic        chk_dd;
        logic [4:0]  exp_dest;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [2:0] v, logic [4:0] d0, logic [4:0] d1, logic [4:0] d2,
                                logic [31:0] x0, logic [31:0] x1, logic [31:0] x2,
                                logic [2:0] rdy, logic we, logic chk, logic [4:0] ed,
                                logic [31:0] ex);
        vec_t r;
        r.valid = v; r.d0 = d0; r.d1 = d1; r.d2 = d2;
        r.x0 = x0; r.x1 = x1; r.x2 = x2;
        r.exp_ready = rdy; r.exp_we = we; r.chk_dd = chk; r.exp_dest = ed; r.exp_data = ex;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [4:0] d0, input logic [4:0] d1,
                         input logic [4:0] d2, input logic [31:0] x0, input logic [31:0] x1,
                         input logic [31:0] x2);
        req_valid_pi = v;
        req_dest_pi  = {d2, d1, d0};
        req_data_pi  = {x2, x1, x0};
    endtask

    task automatic check_zero(input string tag);
        check({tag, " we"}, 64'(we_po), 64'd0);
        check({tag, " dest"}, 64'(destReg_po), 64'd0);
        check({tag, " data"}, 64'(writeData_po), 64'd0);
        check({tag, " init_done"}, 64'(init_done_po), 64'd0);
        check({tag, " ready"}, 64'(req_ready_po), 64'd0);
    endtask

    // Expects reset_n just released #1 after a rising edge; requests held valid.
    task automatic sweep_check(input string tag);
        req_valid_pi = 3'b111;
        for (int k = 0; k < 32; k++) begin
            @(posedge clk); #1;
            check({tag, " sweep we"}, 64'(we_po), 64'd1);
            check({tag, " sweep dest"}, 64'(destReg_po), 64'(k));
            check({tag, " sweep data"}, 64'(writeData_po), 64'd0);
            check({tag, " sweep ready"}, 64'(req_ready_po), 64'd0);
            check({tag, " sweep init_done"}, 64'(init_done_po), 64'd0);
        end
        req_valid_pi = 3'b000;
        @(posedge clk); #1;
        check({tag, " init_done after sweep"}, 64'(init_done_po), 64'd1);
        check({tag, " we after sweep"}, 64'(we_po), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);
        #1;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset held");
        reset_n = 1'b1;
        sweep_check("init");

        //          valid   d0  d1  d2   x0            x1       x2       rdy    we chk dest data
        vecs.push_back(mk(3'b001, 5, 0, 0, 32'hDEADBEEF, 0, 0, 3'b001, 1, 1, 5, 32'hDEADBEEF));
        vecs.push_back(mk(3'b100, 0, 0, 3, 0, 0, 32'h33, 3'b100, 1, 1, 3, 32'h33));
        for (int r = 0; r < 2; r++) begin
            vecs.push_back(mk(3'b111, 1, 2, 4, 32'h11, 32'h22, 32'h44, 3'b001, 1, 1, 1, 32'h11));
            vecs.push_back(mk(3'b111, 1, 2, 4, 32'h11, 32'h22, 32'h44, 3'b010, 1, 1, 2, 32'h22));
            vecs.push_back(mk(3'b111, 1, 2, 4, 32'h11, 32'h22, 32'h44, 3'b100, 1, 1, 4, 32'h44));
        end
        vecs.push_back(mk(3'b010, 0, 0, 0, 0, 32'h1234, 0, 3'b010, 0, 0, 0, 0));
        vecs.push_back(mk(3'b111, 1, 0, 4, 32'h11, 32'h1234, 32'h44, 3'b100, 1, 1, 4, 32'h44));
        vecs.push_back(mk(3'b010, 0, 9, 0, 0, 32'h99, 0, 3'b010, 1, 1, 9, 32'h99));
        vecs.push_back(mk(3'b101, 7, 0, 7, 32'hA, 0, 32'hB, 3'b100, 1, 1, 7, 32'hB));
        vecs.push_back(mk(3'b001, 7, 0, 0, 32'hA, 0, 0, 3'b001, 1, 1, 7, 32'hA));
        vecs.push_back(mk(3'b000, 7, 0, 0, 32'hA, 0, 0, 3'b000, 0, 1, 7, 32'hA));
        vecs.push_back(mk(3'b101, 3, 0, 8, 32'h3, 0, 32'h8, 3'b100, 1, 1, 8, 32'h8));
        vecs.push_back(mk(3'b010, 0, 6, 0, 0, 32'h66, 0, 3'b010, 1, 1, 6, 32'h66));
        vecs.push_back(mk(3'b001, 2, 0, 0, 32'h2, 0, 0, 3'b001, 1, 1, 2, 32'h2));

        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].d0, vecs[i].d1, vecs[i].d2,
                  vecs[i].x0, vecs[i].x1, vecs[i].x2);
            #1;
            check($sformatf("vec%0d ready", i), 64'(req_ready_po), 64'(vecs[i].exp_ready));
            @(posedge clk); #1;
            check($sformatf("vec%0d we", i), 64'(we_po), 64'(vecs[i].exp_we));
            if (vecs[i].chk_dd) begin
                check($sformatf("vec%0d dest", i), 64'(destReg_po), 64'(vecs[i].exp_dest));
                check($sformatf("vec%0d data", i), 64'(writeData_po), 64'(vecs[i].exp_data));
            end
        end

        // Reset mid-arbitration: pointer is 1, so req1 wins; then reset drops it all.
        drive(3'b111, 1, 2, 4, 32'h11, 32'h22, 32'h44);
        #1;
        check("arb ready before reset", 64'(req_ready_po), 64'b010);
        @(posedge clk); #1;
        check("arb write before reset", 64'({we_po, destReg_po}), 64'({1'b1, 5'd2}));
        reset_n = 1'b0;
        #1;
        check_zero("arb reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        sweep_check("post-arb");
        drive(3'b111, 1, 2, 4, 32'h11, 32'h22, 32'h44);
        #1;
        check("pointer cleared by reset", 64'(req_ready_po), 64'b001);
        @(posedge clk); #1;
        req_valid_pi = 3'b000;

        // Reset pulsed while the sweep is at index 10.
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        req_valid_pi = 3'b111;
        repeat (11) @(posedge clk);
        #1;
        check("mid-sweep dest", 64'(destReg_po), 64'd10);
        check("mid-sweep we", 64'(we_po), 64'd1);
        reset_n = 1'b0;
        #1;
        check_zero("mid-sweep reset");
        @(posedge clk); #1;
        check_zero("mid-sweep reset held");
        reset_n = 1'b1;
        sweep_check("restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
